// File: rtl/tt_rng_pkg.sv
// rtl/tt_rng_pkg.sv - shared types and default health-test thresholds for the RNG receiver
package tt_rng_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAIL   = 2'd2
    } rng_state_e;

    localparam int REP_CUTOFF_DEF = 8;
    localparam int APT_WINDOW_DEF = 64;
    localparam int APT_CUTOFF_DEF = 48;

endpackage

// File: rtl/tt_rng_receiver_if.sv
// rtl/tt_rng_receiver_if.sv - byte delivery handshake between the receiver and its consumer
interface tt_rng_receiver_if;

    logic [7:0] byte_out;
    logic       byte_valid;
    logic       out_ready;

    modport master (
        output byte_out,
        output byte_valid,
        input  out_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        output out_ready
    );

endinterface

// File: rtl/tt_rng_health.sv
// rtl/tt_rng_health.sv - repetition-count and adaptive-proportion tests on the raw bit stream
module tt_rng_health
    import tt_rng_pkg::*;
#(
    parameter int REP_CUTOFF = REP_CUTOFF_DEF,
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clear,
    input  logic freeze,
    output logic rep_fail,
    output logic prop_fail,
    output logic rep_hit,
    output logic prop_hit,
    output logic win_done
);

    localparam int REP_W   = $clog2(REP_CUTOFF + 1);
    localparam int POS_W   = $clog2(APT_WINDOW + 1);
    localparam int MATCH_W = $clog2(APT_CUTOFF + 1);

    logic [REP_W-1:0]   run_q, run_d;
    logic               last_q, last_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               ref_q, ref_d;
    logic               rep_fail_q, rep_fail_d;
    logic               prop_fail_q, prop_fail_d;
    logic               accept;

    assign accept = bit_en && !freeze && !clear;

    always_comb begin
        run_d       = run_q;
        last_d      = last_q;
        pos_d       = pos_q;
        match_d     = match_q;
        ref_d       = ref_q;
        rep_fail_d  = rep_fail_q;
        prop_fail_d = prop_fail_q;
        rep_hit     = 1'b0;
        prop_hit    = 1'b0;
        win_done    = 1'b0;

        if (clear) begin
            run_d       = '0;
            last_d      = 1'b0;
            pos_d       = '0;
            match_d     = '0;
            ref_d       = 1'b0;
            rep_fail_d  = 1'b0;
            prop_fail_d = 1'b0;
        end else if (accept) begin
            // run_q == 0 marks "no bit seen yet" after reset or clear
            last_d = bit_in;
            if (run_q == '0 || bit_in != last_q) begin
                run_d = REP_W'(1);
            end else if (run_q != REP_W'(REP_CUTOFF)) begin
                run_d = run_q + 1'b1;
            end

            if (pos_q == '0) begin
                ref_d   = bit_in;
                match_d = MATCH_W'(1);
            end else if (bit_in == ref_q && match_q != MATCH_W'(APT_CUTOFF)) begin
                match_d = match_q + 1'b1;
            end

            if (pos_q == POS_W'(APT_WINDOW - 1)) begin
                pos_d    = '0;
                win_done = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end

            rep_hit     = (run_d == REP_W'(REP_CUTOFF));
            prop_hit    = (match_d == MATCH_W'(APT_CUTOFF));
            rep_fail_d  = rep_fail_q | rep_hit;
            prop_fail_d = prop_fail_q | prop_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            last_q      <= 1'b0;
            pos_q       <= '0;
            match_q     <= '0;
            ref_q       <= 1'b0;
            rep_fail_q  <= 1'b0;
            prop_fail_q <= 1'b0;
        end else begin
            run_q       <= run_d;
            last_q      <= last_d;
            pos_q       <= pos_d;
            match_q     <= match_d;
            ref_q       <= ref_d;
            rep_fail_q  <= rep_fail_d;
            prop_fail_q <= prop_fail_d;
        end
    end

    assign rep_fail  = rep_fail_q;
    assign prop_fail = prop_fail_q;

endmodule

// File: rtl/tt_rng_receiver.sv
// rtl/tt_rng_receiver.sv - health-gated TRNG bit receiver packing bits into handshaked bytes
module tt_rng_receiver
    import tt_rng_pkg::*;
#(
    parameter int REP_CUTOFF = REP_CUTOFF_DEF,
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bit_in,
    input  logic                      bit_en,
    input  logic                      clr_flags,
    tt_rng_receiver_if.master         out_if,
    output logic                      health_ok,
    output logic                      rep_fail,
    output logic                      prop_fail,
    output logic                      overrun
);

    rng_state_e state_q, state_d;
    logic [6:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       health_ok_q, health_ok_d;

    logic accept;
    logic fail_now;
    logic rep_hit;
    logic prop_hit;
    logic win_done;

    tt_rng_health #(
        .REP_CUTOFF (REP_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .clear     (clr_flags),
        .freeze    (state_q == ST_FAIL),
        .rep_fail  (rep_fail),
        .prop_fail (prop_fail),
        .rep_hit   (rep_hit),
        .prop_hit  (prop_hit),
        .win_done  (win_done)
    );

    assign accept   = bit_en && !clr_flags && (state_q != ST_FAIL);
    assign fail_now = accept && (rep_hit || prop_hit);

    always_comb begin
        state_d = state_q;
        if (clr_flags) begin
            state_d = ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (fail_now) begin
                        state_d = ST_FAIL;
                    end else if (accept && win_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fail_now) begin
                        state_d = ST_FAIL;
                    end
                end
                default: state_d = ST_FAIL;
            endcase
        end
    end

    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        valid_d     = valid_q && !out_if.out_ready;
        overrun_d   = overrun_q;
        health_ok_d = (state_d == ST_RUN);

        if (clr_flags) begin
            sh_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            sh_d  = {sh_q[5:0], bit_in};
            cnt_d = cnt_q + 3'd1;

            // a byte whose last bit trips a health test never leaves the block
            if (state_q == ST_RUN && cnt_q == 3'd7 && !fail_now) begin
                if (!valid_q || out_if.out_ready) begin
                    byte_d  = {sh_q, bit_in};
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end

            if (state_q == ST_WARMUP && win_done && !fail_now) begin
                sh_d  = '0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WARMUP;
            sh_q        <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            health_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            health_ok_q <= health_ok_d;
        end
    end

    assign out_if.byte_out   = byte_q;
    assign out_if.byte_valid = valid_q;
    assign health_ok         = health_ok_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_tt_rng_receiver.sv
// tb/tb_tt_rng_receiver.sv - directed self-checking bench for tt_rng_receiver
module tb_tt_rng_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b0;
    logic bit_en = 1'b0;
    logic clr_flags = 1'b0;
    logic health_ok, rep_fail, prop_fail, overrun;

    int checks = 0;
    int errors = 0;

    tt_rng_receiver_if out_if ();

    tt_rng_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .clr_flags (clr_flags),
        .out_if    (out_if.master),
        .health_ok (health_ok),
        .rep_fail  (rep_fail),
        .prop_fail (prop_fail),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b, input logic rdy);
        @(negedge clk);
        bit_in = b;
        bit_en = 1'b1;
        out_if.out_ready = rdy;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        @(negedge clk);
        bit_en = 1'b0;
        out_if.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_if.byte_out, out_if.byte_valid, health_ok, rep_fail, prop_fail, overrun} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_if.byte_out, out_if.byte_valid, health_ok, rep_fail, prop_fail, overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_warmup;
        int vcount = 0;
        for (int i = 0; i < 64; i++) begin
            send_bit(i[0], 1'b1);
            if (out_if.byte_valid) vcount++;
            if (i == 62) begin
                checks++;
                if (health_ok !== 1'b0) begin
                    errors++;
                    $display("FAIL warmup_early_ok: got %b expected 0", health_ok);
                end
            end
        end
        checks++;
        if (health_ok !== 1'b1) begin
            errors++;
            $display("FAIL warmup_ok: got %b expected 1", health_ok);
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL warmup_no_byte: got %0d valid cycles expected 0", vcount);
        end
    endtask

    task automatic test_byte_b2;
        logic [7:0] pat = 8'hB2;
        int vcount = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[7-i], 1'b1);
            if (i < 7 && out_if.byte_valid) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL b2_early_valid: got %0d expected 0", vcount);
        end
        checks++;
        if (out_if.byte_valid !== 1'b1 || out_if.byte_out !== 8'hB2) begin
            errors++;
            $display("FAIL b2_byte: got valid=%b byte=%h expected valid=1 byte=b2",
                     out_if.byte_valid, out_if.byte_out);
        end
        idle(1'b1);
        checks++;
        if (out_if.byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2_pulse_end: got %b expected 0", out_if.byte_valid);
        end
    endtask

    task automatic test_rep_fail;
        int vcount = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b1);
            if (out_if.byte_valid) vcount++;
        end
        checks++;
        if ({rep_fail, prop_fail, health_ok} !== 3'b100) begin
            errors++;
            $display("FAIL rep_flags: got rep/prop/ok=%b expected 100", {rep_fail, prop_fail, health_ok});
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL rep_byte_discard: got %0d valid cycles expected 0", vcount);
        end
    endtask

    task automatic test_clear;
        @(negedge clk);
        clr_flags = 1'b1;
        bit_en = 1'b1;
        bit_in = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        bit_en = 1'b0;
        checks++;
        if ({rep_fail, prop_fail, overrun, health_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL clear_flags: got %b expected 0000", {rep_fail, prop_fail, overrun, health_ok});
        end
        for (int i = 0; i < 63; i++) send_bit(i[0], 1'b1);
        checks++;
        if (health_ok !== 1'b0) begin
            errors++;
            $display("FAIL clear_bit_ignored: got health_ok=%b expected 0 after 63 bits", health_ok);
        end
        send_bit(1'b1, 1'b1);
        checks++;
        if (health_ok !== 1'b1) begin
            errors++;
            $display("FAIL clear_rewarm: got %b expected 1", health_ok);
        end
    endtask

    task automatic test_prop_fail;
        for (int i = 0; i < 63; i++) begin
            send_bit((i % 4) != 3, 1'b1);
            if (i == 7) begin
                checks++;
                if (out_if.byte_valid !== 1'b1 || out_if.byte_out !== 8'hEE) begin
                    errors++;
                    $display("FAIL prop_first_byte: got valid=%b byte=%h expected valid=1 byte=ee",
                             out_if.byte_valid, out_if.byte_out);
                end
            end
            if (i == 61) begin
                checks++;
                if (prop_fail !== 1'b0) begin
                    errors++;
                    $display("FAIL prop_early: got %b expected 0", prop_fail);
                end
            end
        end
        checks++;
        if ({prop_fail, rep_fail, health_ok} !== 3'b100) begin
            errors++;
            $display("FAIL prop_flags: got prop/rep/ok=%b expected 100", {prop_fail, rep_fail, health_ok});
        end
    endtask

    task automatic test_overrun;
        logic [7:0] a5 = 8'hA5;
        logic [7:0] c3 = 8'h3C;
        int unstable = 0;
        @(negedge clk);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        for (int i = 0; i < 64; i++) send_bit(i[0], 1'b1);
        checks++;
        if (health_ok !== 1'b1) begin
            errors++;
            $display("FAIL ovr_warm: got %b expected 1", health_ok);
        end
        idle(1'b1);
        for (int i = 0; i < 8; i++) send_bit(a5[7-i], 1'b0);
        checks++;
        if ({out_if.byte_valid, out_if.byte_out, overrun} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL ovr_a5: got valid=%b byte=%h ovr=%b expected 1 a5 0",
                     out_if.byte_valid, out_if.byte_out, overrun);
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(c3[7-i], 1'b0);
            if (out_if.byte_out !== 8'hA5) unstable++;
        end
        checks++;
        if (unstable != 0 || overrun !== 1'b1 || out_if.byte_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: got unstable=%0d ovr=%b valid=%b expected 0 1 1",
                     unstable, overrun, out_if.byte_valid);
        end
        for (int i = 0; i < 8; i++) send_bit(c3[7-i], (i == 7));
        checks++;
        if ({out_if.byte_valid, out_if.byte_out, overrun} !== {1'b1, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL ovr_reload: got valid=%b byte=%h ovr=%b expected 1 3c 1",
                     out_if.byte_valid, out_if.byte_out, overrun);
        end
    endtask

    task automatic test_reset_mid;
        int vcount = 0;
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_if.byte_out, out_if.byte_valid, health_ok, rep_fail, prop_fail, overrun} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {out_if.byte_out, out_if.byte_valid, health_ok, rep_fail, prop_fail, overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 63; i++) begin
            send_bit(i[0], 1'b1);
            if (out_if.byte_valid) vcount++;
        end
        checks++;
        if (health_ok !== 1'b0 || vcount != 0) begin
            errors++;
            $display("FAIL reset_rewarm_early: got ok=%b valid_cycles=%0d expected 0 0", health_ok, vcount);
        end
        send_bit(1'b1, 1'b1);
        checks++;
        if (health_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_rewarm: got %b expected 1", health_ok);
        end
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        test_reset();
        test_warmup();
        test_byte_b2();
        test_rep_fail();
        test_clear();
        test_prop_fail();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_rng_receiver.md
# tt_rng_receiver

Consumer end of the TRNG serial bit stream: accepts one random bit per strobe, runs continuous health tests (repetition-count and adaptive-proportion), and packs healthy bits into bytes delivered over a valid/ready handshake. Sits downstream of the whitened `ranbitstring` output and is the reader for everything the ring-oscillator/LFSR path writes.

## Interface
- `REP_CUTOFF`, default 8: a run of this many identical bits fails the repetition test.
- `APT_WINDOW`, default 64: adaptive-proportion window length in bits; also the warm-up length.
- `APT_CUTOFF`, default 48: this many matches of the window's first bit within one window fails the proportion test.

- `clk`, input, 1: sole clock; all state updates on posedge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `bit_in`, input, 1: random bit; sampled only when `bit_en`=1.
- `bit_en`, input, 1: bit strobe; one bit accepted per cycle it is high.
- `clr_flags`, input, 1: synchronous clear of fail/overrun flags and restart of tests.
- `out_ready`, input, 1: downstream accepts `byte_out` this cycle.
- `byte_out`, output, 8: assembled byte, first received bit in bit 7.
- `byte_valid`, output, 1: `byte_out` holds an undelivered byte.
- `health_ok`, output, 1: high only in state RUN.
- `rep_fail`, output, 1: sticky repetition-test failure.
- `prop_fail`, output, 1: sticky proportion-test failure.
- `overrun`, output, 1: sticky; a completed byte was dropped under backpressure.

## Operation
- States: WARMUP, RUN, FAIL. Reset → WARMUP.
- WARMUP → RUN when the first full `APT_WINDOW` completes with no failure. Bit/byte counter cleared on entry to RUN; bytes assembled during WARMUP discarded.
- WARMUP or RUN → FAIL on any test failure. FAIL → WARMUP only on `clr_flags`.
- Repetition test: first bit after reset/clear sets last=bit, run=1. Equal bit: run+1; different: run=1. Run reaching `REP_CUTOFF` sets `rep_fail`.
- Proportion test: window position 0 captures ref bit, match=1; each later bit equal to ref increments match. Match reaching `APT_CUTOFF` sets `prop_fail`. After `APT_WINDOW` bits, position wraps to 0.
- Both tests run in every state except FAIL (frozen in FAIL).
- Assembly: shift `{sh[6:0], bit_in}` per accepted bit; 3-bit counter wraps 7→0. On the 8th bit in RUN with no failure that cycle: if `byte_valid`=0 or `out_ready`=1, load `byte_out`, `byte_valid`=1; else drop byte, set `overrun`.
- Handshake: transfer when `byte_valid`&&`out_ready`; `byte_valid` clears unless a new byte loads that same cycle. `byte_out` stable while `byte_valid`&&!`out_ready`.
- `clr_flags`: clears `rep_fail`, `prop_fail`, `overrun`, test counters, shifter and bit counter; state → WARMUP; `byte_valid`/`byte_out` unaffected. Wins over a simultaneous `bit_en` (bit discarded).
- Failure on the same bit that completes a byte: byte discarded, no `byte_valid`.

## Timing
- Reset values: `byte_out`=0, `byte_valid`=0, `health_ok`=0, all flags 0, state WARMUP, counters 0.
- All outputs registered. `byte_valid` rises on the edge sampling the 8th bit, visible next cycle.
- Fail flags and `health_ok`=0 visible the cycle after the failing bit's edge.
- `health_ok` rises the cycle after the edge sampling bit `APT_WINDOW`.
- Async reset mid-byte: all state returns to reset values immediately; partial byte lost.
- Counter widths: `$clog2(N+1)` of respective parameter; no wrap beyond cutoff (fail first).

## Structure
- Package `tt_rng_pkg`: state enum (WARMUP/RUN/FAIL), default cutoff/window constants.
- Sub-module `tt_rng_health`: both health tests, inputs bit/strobe/clear/freeze, outputs sticky fails and window-complete pulse. Top holds FSM, shifter, output register.

## Test plan
- Reset, 64 bits alternating 0,1 → `health_ok`=1 after 64th, no byte; then 1,0,1,1,0,0,1,0 with `out_ready`=1 → one `byte_valid` pulse, `byte_out`=0xB2.
- In RUN, 8 consecutive 1s → `rep_fail`=1, `health_ok`=0, no `byte_valid` (0xFF discarded).
- New window with 48 ones among 16 zeros, no run ≥8 → `prop_fail`=1 at 48th match, `rep_fail`=0.
- `out_ready`=0, deliver 0xA5 then 0x3C → `byte_out` stays 0xA5, `overrun`=1; raise `out_ready` on the cycle 0x3C completes (fresh run) → 0x3C loads, `overrun` unchanged.
- In FAIL assert `clr_flags` with `bit_en`=1 → flags 0, WARMUP, bit ignored, `health_ok`=0 until 64 further bits.
- Drop `rst_n` after 5 bits of a byte → outputs 0 immediately; after release, full 64-bit warm-up required.
